sram_port_arbiter: RTL

Shares one synchronous single-port SRAM between the CPU's instruction-fetch requester and its data load/store requester. Data accesses normally win arbitration. A starvation counter guarantees that a waiting fetch eventually gets through. The block issues at most one SRAM access per cycle, tracks which requester owns the read in flight, and routes the one-cycle-latency read data back to that requester with a valid pulse.

---
 rtl/sram_port_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one synchronous single-port SRAM between an instruction-fetch
//   requester and a data load/store requester. Data wins by default; a
//   starvation counter forces a pending fetch through after STARVE_MAX
//   consecutive denied cycles. One SRAM access per cycle, fully pipelined.
//   Read data returns one cycle after the grant, steered to the requester
//   that owned the read, with a one-cycle rvalid pulse.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   inst_req/addr       fetch request (held until inst_gnt)
//   inst_gnt            fetch accepted this cycle
//   inst_rvalid/rdata   fetch read response
//   data_req/we/addr/wdata  data request (held until data_gnt)
//   data_gnt            data accepted this cycle (store completion ack)
//   data_rvalid/rdata   load read response
//   sram_en/we/addr/wdata   SRAM access, all zero when nothing is granted
//   sram_rdata          SRAM read data, valid the cycle after a read
module sram_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_gnt,
  output logic              inst_rvalid,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [1:0] {IDLE, RD_I, RD_D} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       fetch_force;

  // Grants are held off while reset is asserted so nothing reaches the
  // SRAM and no response is launched from a request seen during reset.
  always_comb begin
    fetch_force = inst_req && (starve_cnt_q >= STARVE_LIM);
    data_gnt    = !reset && data_req && !fetch_force;
    inst_gnt    = !reset && inst_req && !data_gnt;
  end

  always_comb begin
    sram_en    = inst_gnt | data_gnt;
    sram_we    = data_gnt && data_we;
    sram_addr  = '0;
    sram_wdata = '0;
    if (data_gnt) begin
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (inst_gnt) begin
      sram_addr  = inst_addr;
    end
  end

  // Starvation counter: counts cycles a pending fetch loses to data.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!inst_req || inst_gnt) begin
      starve_cnt_d = '0;
    end else if (data_gnt && (starve_cnt_q != 4'hf)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Response FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Response FSM: next state follows this cycle's grant, from any state
  always_comb begin
    state_d = IDLE;
    if (inst_gnt) begin
      state_d = RD_I;
    end else if (data_gnt && !data_we) begin
      state_d = RD_D;
    end
  end

  // Response FSM: outputs. A read in flight when reset rises is dropped.
  always_comb begin
    inst_rvalid = (state_q == RD_I) && !reset;
    data_rvalid = (state_q == RD_D) && !reset;
    inst_rdata  = inst_rvalid ? sram_rdata : '0;
    data_rdata  = data_rvalid ? sram_rdata : '0;
  end

endmodule
